alu_arbiter: RTL

Shares the single 64-bit integer ALU between two requesters: port 0, the execute stage, and port 1, the address/branch helper. Runs a round-robin grant with valid/ready handshakes on both sides. Each granted operation is registered into one output stage, so every result appears exactly one cycle after grant. The ALU itself is instantiated inside this block and is not visible to requesters.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter_alu.sv | 27 ++
 rtl/alu_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: widths, opcodes
// and requester port identifiers.
package alu_pkg;

  localparam int DW  = 64;
  localparam int OPW = 4;

  localparam logic [OPW-1:0] ALU_ADD = 4'b0000;
  localparam logic [OPW-1:0] ALU_SUB = 4'b1000;
  localparam logic [OPW-1:0] ALU_SLL = 4'b0001;
  localparam logic [OPW-1:0] ALU_SLT = 4'b0010;
  localparam logic [OPW-1:0] ALU_XOR = 4'b0100;
  localparam logic [OPW-1:0] ALU_SRL = 4'b0101;
  localparam logic [OPW-1:0] ALU_SRA = 4'b1101;
  localparam logic [OPW-1:0] ALU_OR  = 4'b0110;
  localparam logic [OPW-1:0] ALU_AND = 4'b0111;

  localparam logic PORT_EXE = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
// The master side is the requesters plus their response consumers.
interface alu_arbiter_if #(
  parameter int DW  = alu_pkg::DW,
  parameter int OPW = alu_pkg::OPW
);

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;

  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit integer ALU. Unknown opcodes fall back to add and
// shift amounts use only b[5:0].
module ALU
  import alu_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [DW-1:0]  result
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_SLL: result = a << b[5:0];
      ALU_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR: result = a ^ b;
      ALU_SRL: result = a >> b[5:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[5:0]);
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and
// the address/branch helper (port 1), with a single registered output stage.
module alu_arbiter #(
  parameter int DW  = alu_pkg::DW,
  parameter int OPW = alu_pkg::OPW
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  import alu_pkg::*;

  logic           out_full_q, out_full_d;
  logic           out_id_q, out_id_d;
  logic           zero_q, zero_d;
  logic           prio_q, prio_d;
  logic [DW-1:0]  result_q, result_d;

  logic           drain;
  logic           can_issue;
  logic           grant0;
  logic           grant1;
  logic           granted;
  logic           grant_id;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;

  // A held response frees the stage in the same cycle its consumer takes it,
  // which is the only path from rsp*_ready to req*_ready.
  always_comb begin
    drain     = out_full_q && ((out_id_q == PORT_AUX) ? bus.rsp1_ready : bus.rsp0_ready);
    can_issue = !out_full_q || drain;
    grant0    = rst_n && can_issue && bus.req0_valid &&
                (!bus.req1_valid || (prio_q == PORT_EXE));
    grant1    = rst_n && can_issue && bus.req1_valid &&
                (!bus.req0_valid || (prio_q == PORT_AUX));
    granted   = grant0 || grant1;
    grant_id  = grant1 ? PORT_AUX : PORT_EXE;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    alu_op = bus.req0_op;
    alu_a  = bus.req0_a;
    alu_b  = bus.req0_b;
    if (grant_id == PORT_AUX) begin
      alu_op = bus.req1_op;
      alu_a  = bus.req1_a;
      alu_b  = bus.req1_b;
    end
  end

  ALU u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  // prio always points at the port that lost (or was not granted) last time.
  always_comb begin
    out_full_d = out_full_q;
    out_id_d   = out_id_q;
    result_d   = result_q;
    zero_d     = zero_q;
    prio_d     = prio_q;
    if (granted) begin
      out_full_d = 1'b1;
      out_id_d   = grant_id;
      result_d   = alu_result;
      zero_d     = (alu_result == '0);
      prio_d     = ~grant_id;
    end else if (drain) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full_q <= 1'b0;
      out_id_q   <= PORT_EXE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      prio_q     <= PORT_EXE;
    end else begin
      out_full_q <= out_full_d;
      out_id_q   <= out_id_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      prio_q     <= prio_d;
    end
  end

  assign bus.rsp0_valid = out_full_q && (out_id_q == PORT_EXE);
  assign bus.rsp1_valid = out_full_q && (out_id_q == PORT_AUX);
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;

endmodule
